fa_bist_checker: RTL and testbench

//  Built-in self-test engine for the 1-bit full adder; the hardware counterpart of the stimulus bench.

---
 rtl/fa_bist_checker.sv | 148 ++++++++++++++
 tb/tb_fa_bist_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fa_bist_checker.sv
// Self-test engine for a 1-bit full adder: walks all 8 operand vectors,
// checks S/Cout against the golden sum and reports a saturating error count.
module fa_bist_checker #(
    parameter int LATENCY = 0,
    parameter int ERR_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             x1_o,
    output logic             x2_o,
    output logic             cin_o,
    input  logic             s_in,
    input  logic             cout_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [3:0]       wait_q, wait_d;
    logic [2:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [2:0]       fvec_q, fvec_d;

    logic exp_s;
    logic exp_c;
    logic mismatch;

    assign exp_s = vec_q[2] ^ vec_q[1] ^ vec_q[0];
    assign exp_c = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0])
                 | (vec_q[1] & vec_q[0]);
    assign mismatch = (s_in != exp_s) || (cout_in != exp_c);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                op_d = 3'b000;
                if (start) begin
                    state_d = S_APPLY;
                    vec_d   = 3'd0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = 3'd0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_APPLY: begin
                // Operands become visible on this edge; the response is
                // judged LATENCY+1 edges later.
                op_d    = vec_q;
                wait_d  = WAIT_INIT;
                state_d = (LATENCY == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 4'd0) state_d = S_CHECK;
                else                wait_d  = wait_q - 4'd1;
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    op_d    = 3'b000;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= 3'd0;
            wait_q  <= 4'd0;
            op_q    <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
        end
    end

    assign {x1_o, x2_o, cin_o} = op_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: a combinational-adder instance (LATENCY=0)
// and a 2-stage pipelined-adder instance (LATENCY=2, ERR_W=2).
module tb_fa_bist_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start = 2'b00;
    logic [1:0] x1, x2, ci;
    logic [1:0] s_in, c_in;
    logic [1:0] busy, done, pass, fv;
    logic [2:0] fvec [2];
    logic [3:0] errc [2];
    logic [1:0] errc_b;
    logic [2:0] ops [2];

    logic [7:0] fs [2];
    logic [7:0] fc [2];
    logic       dly = 1'b0;
    logic [2:0] dq_a;
    logic [2:0] p1_b, p2_b;
    logic [2:0] src_a;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fa_bist_checker #(.LATENCY(0), .ERR_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .x1_o(x1[0]), .x2_o(x2[0]), .cin_o(ci[0]),
        .s_in(s_in[0]), .cout_in(c_in[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .fail_valid(fv[0]), .fail_vec(fvec[0])
    );

    fa_bist_checker #(.LATENCY(2), .ERR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .x1_o(x1[1]), .x2_o(x2[1]), .cin_o(ci[1]),
        .s_in(s_in[1]), .cout_in(c_in[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc_b), .fail_valid(fv[1]), .fail_vec(fvec[1])
    );

    assign errc[1] = {2'b00, errc_b};
    assign ops[0]  = {x1[0], x2[0], ci[0]};
    assign ops[1]  = {x1[1], x2[1], ci[1]};

    // Golden adder as plain arithmetic: {cout, s} = x1 + x2 + cin.
    function automatic logic [1:0] fa(input logic [2:0] v);
        return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
    endfunction

    always @(posedge clk) begin
        dq_a <= ops[0];
        p1_b <= ops[1];
        p2_b <= p1_b;
    end

    always_comb begin
        src_a = dly ? dq_a : ops[0];
        {c_in[0], s_in[0]} = fa(src_a) ^ {fc[0][src_a], fs[0][src_a]};
        {c_in[1], s_in[1]} = fa(p2_b) ^ {fc[1][p2_b], fs[1][p2_b]};
    end

    typedef struct {
        int         k;
        logic [7:0] fs;
        logic [7:0] fc;
        bit         dly;
        int         mid;
        int         exp_err;
        bit         exp_fv;
        logic [2:0] exp_fvec;
        bit         exp_pass;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: every vector with a corrupted response counts once,
    // clipped at the counter ceiling; the lowest such vector is reported.
    function automatic vec_t model(input int k, input logic [7:0] s_m,
                                   input logic [7:0] c_m, input int mid);
        vec_t       r;
        logic [7:0] bad;
        int         n;
        int         sat;
        bad = s_m | c_m;
        n   = $countones(bad);
        sat = (k == 1) ? 3 : 15;
        r.k = k; r.fs = s_m; r.fc = c_m; r.dly = 0; r.mid = mid;
        r.exp_err  = (n > sat) ? sat : n;
        r.exp_fv   = (n > 0);
        r.exp_fvec = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (bad[i]) r.exp_fvec = 3'(i);
        r.exp_pass = (n == 0);
        return r;
    endfunction

    task automatic run_vec(input vec_t t);
        int         cyc;
        bit         fin;
        logic [2:0] last;
        logic [2:0] seq [$];
        fs[t.k] = t.fs;
        fc[t.k] = t.fc;
        dly     = t.dly;
        @(negedge clk);
        start[t.k] = 1'b1;
        @(negedge clk);
        start[t.k] = 1'b0;
        chk("clear_done", int'(done[t.k]), 0);
        chk("clear_err", int'(errc[t.k]), 0);
        cyc  = 0;
        fin  = 0;
        last = 3'd0;
        for (int i = 0; i < 100 && !fin; i++) begin
            if (busy[t.k]) begin
                cyc++;
                if (ops[t.k] != last) begin
                    seq.push_back(ops[t.k]);
                    last = ops[t.k];
                end
            end
            if (done[t.k]) fin = 1;
            else begin
                if (cyc == t.mid) start[t.k] = 1'b1;
                @(negedge clk);
                start[t.k] = 1'b0;
            end
        end
        chk("timeout", int'(fin), 1);
        chk("run_len", cyc, (t.k == 1) ? 32 : 16);
        chk("seq_len", seq.size(), 7);
        foreach (seq[j]) chk("drive_seq", int'(seq[j]), j + 1);
        chk("err_count", int'(errc[t.k]), t.exp_err);
        chk("fail_valid", int'(fv[t.k]), int'(t.exp_fv));
        chk("fail_vec", int'(fvec[t.k]), int'(t.exp_fvec));
        chk("pass", int'(pass[t.k]), int'(t.exp_pass));
        chk("busy_end", int'(busy[t.k]), 0);
        chk("ops_end", int'(ops[t.k]), 0);
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk({tag, "_busy"}, int'(busy[k]), 0);
        chk({tag, "_done"}, int'(done[k]), 0);
        chk({tag, "_pass"}, int'(pass[k]), 0);
        chk({tag, "_fv"}, int'(fv[k]), 0);
        chk({tag, "_err"}, int'(errc[k]), 0);
        chk({tag, "_fvec"}, int'(fvec[k]), 0);
        chk({tag, "_ops"}, int'(ops[k]), 0);
    endtask

    initial begin
        vec_t e;
        bit   hit;
        fs[0] = 8'h00; fs[1] = 8'h00;
        fc[0] = 8'h00; fc[1] = 8'h00;

        tbl.push_back(model(0, 8'h00, 8'h00, -1));
        tbl.push_back(model(0, 8'h96, 8'h00, -1));
        tbl.push_back(model(0, 8'h00, 8'h00, 5));
        tbl.push_back(model(1, 8'h00, 8'hFF, -1));
        tbl.push_back(model(1, 8'h00, 8'h00, -1));
        tbl.push_back(model(1, 8'h00, 8'h00, 10));
        // Unaligned adder: each check sees the previous vector's answer.
        e = model(0, 8'h00, 8'h00, -1);
        e.dly = 1; e.exp_err = 5; e.exp_fv = 1;
        e.exp_fvec = 3'd1; e.exp_pass = 0;
        tbl.push_back(e);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] rs, rc;
            rs = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            rc = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            tbl.push_back(model(i % 2, rs, rc, -1));
        end

        repeat (3) @(negedge clk);
        chk_zero(0, "rst_a");
        chk_zero(1, "rst_b");
        rst_n = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Abort a faulty run at vector 5, then expect a clean rerun.
        fs[0] = 8'h96; fc[0] = 8'h00; dly = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (ops[0] == 3'b101) hit = 1;
            else @(negedge clk);
        end
        chk("reach_vec5", int'(hit), 1);
        chk("pre_abort_err", int'(errc[0]), 3);
        #2 rst_n = 1'b0;
        #1 chk_zero(0, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(model(0, 8'h00, 8'h00, -1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
